// File: rtl/rram_pkg.sv
// -----------------------------------------------------------------------------
// rram_pkg
// Shared definitions for the RRAM row sequencer: op and bit-line drive
// encodings, the sequencer state enum, the duration counter width, and two
// small helpers used by the top level.
// Optional feature macro: RRAM_VERIFY_EN adds the VERIFY state.
// -----------------------------------------------------------------------------
package rram_pkg;

    localparam int CNT_W = 8;
    typedef logic [CNT_W-1:0] cnt_t;

    typedef enum logic [1:0] {
        OP_READ  = 2'b00,
        OP_SET   = 2'b01,
        OP_RESET = 2'b10,
        OP_NOP   = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        BL_OFF   = 2'b00,
        BL_SET   = 2'b01,
        BL_RESET = 2'b10,
        BL_READ  = 2'b11
    } bl_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_PULSE,
        ST_RECOVER,
        ST_RESP
`ifdef RRAM_VERIFY_EN
        , ST_VERIFY
`endif
    } state_e;

    // Bit-line bias applied during the PULSE state for a given op.
    function automatic bl_e bl_for_op(input op_e op);
        case (op)
            OP_SET:   return BL_SET;
            OP_RESET: return BL_RESET;
            default:  return BL_READ;
        endcase
    endfunction

    // A programmed row verifies when every masked column reads back the
    // target value: 1 after SET, 0 after RESET.
    function automatic logic verify_ok(input op_e op, input logic [31:0] rd,
                                       input logic [31:0] mask);
        if (op == OP_SET)
            return (rd & mask) == mask;
        else
            return (rd & mask) == 32'h0;
    endfunction

endpackage

// File: rtl/rram_pulse_timer.sv
// -----------------------------------------------------------------------------
// rram_pulse_timer
// Loadable 8-bit down-counter used to time every sequencer state.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   load        - load load_val this edge (takes priority over counting)
//   load_val    - N-1 for an N-cycle state
//   done        - count has reached 0 (last cycle of the current state)
// -----------------------------------------------------------------------------
module rram_pulse_timer
    import rram_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  cnt_t load_val,
    output logic done
);

    cnt_t count_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_val;
        end else if (count_reg != '0) begin
            count_reg <= count_reg - 1'b1;
        end
    end

    assign done = (count_reg == '0);

endmodule

// File: rtl/rram_row_sequencer.sv
// -----------------------------------------------------------------------------
// rram_row_sequencer
// Sequences one RRAM row access: word-line settle, bias pulse (READ / SET /
// RESET), discharge, then a one-cycle completion pulse.
// Optional feature macro: RRAM_VERIFY_EN -- after SET/RESET run a read-back
// pass and re-pulse up to MAX_RETRY times on failure.
// Ports:
//   clk, rst_n             - clock, asynchronous active-low reset
//   req_valid/req_ready    - request handshake (ready only in IDLE)
//   req_op, req_row, req_mask - op, target row, columns to program
//   row_en, row_addr       - word-line decoder enable / address
//   bl_drive, sa_en        - bit-line bias select, sense-amp enable
//   rd_data                - sense-amp outputs
//   rsp_valid, rsp_data, rsp_err - completion pulse, read data, error
// -----------------------------------------------------------------------------
module rram_row_sequencer
    import rram_pkg::*;
#(
    parameter int unsigned SETUP_CYC   = 2,
    parameter int unsigned SET_PW      = 8,
    parameter int unsigned RESET_PW    = 12,
    parameter int unsigned READ_PW     = 4,
    parameter int unsigned RECOVER_CYC = 2,
    parameter int unsigned MAX_RETRY   = 3
)
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [4:0]  req_row,
    input  logic [31:0] req_mask,
    output logic        row_en,
    output logic [4:0]  row_addr,
    output logic [1:0]  bl_drive,
    output logic        sa_en,
    input  logic [31:0] rd_data,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic        rsp_err
);

    // Counter load values are N-1: the timer reaches 0 on the Nth cycle.
    localparam cnt_t SETUP_LD   = cnt_t'(SETUP_CYC - 1);
    localparam cnt_t SET_LD     = cnt_t'(SET_PW - 1);
    localparam cnt_t RESET_LD   = cnt_t'(RESET_PW - 1);
    localparam cnt_t READ_LD    = cnt_t'(READ_PW - 1);
    localparam cnt_t RECOVER_LD = cnt_t'(RECOVER_CYC - 1);

    state_e      state_reg;
    state_e      state_next;
    op_e         op_reg;
    logic [4:0]  row_reg;
    logic [31:0] mask_reg;
    logic        req_ready_reg;
    logic        row_en_reg;
    bl_e         bl_drive_reg;
    logic        sa_en_reg;
    logic        rsp_valid_reg;
    logic [31:0] rsp_data_reg;
    logic        rsp_err_reg;

    logic        accept;
    logic        tmr_load;
    cnt_t        tmr_val;
    logic        tmr_done;

`ifdef RRAM_VERIFY_EN
    logic        verify_pass_reg;   // current SETUP/RECOVER belong to a read-back pass
    logic        verify_fail_reg;   // result of the most recent read-back
    logic [2:0]  retry_reg;         // extra program pulses issued so far
`else
    logic        unused_mask;
    assign unused_mask = ^mask_reg;
`endif

    function automatic cnt_t pw_load(input op_e op);
        case (op)
            OP_SET:   return SET_LD;
            OP_RESET: return RESET_LD;
            default:  return READ_LD;
        endcase
    endfunction

    assign accept = req_valid && req_ready_reg;

    rram_pulse_timer u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    // Next-state decode; the timer is reloaded on every state entry that
    // has a duration so it is already counting in the first cycle.
    always_comb begin
        state_next = state_reg;
        tmr_load   = 1'b0;
        tmr_val    = '0;
        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    if (op_e'(req_op) == OP_NOP) begin
                        state_next = ST_RESP;
                    end else begin
                        state_next = ST_SETUP;
                        tmr_load   = 1'b1;
                        tmr_val    = SETUP_LD;
                    end
                end
            end
            ST_SETUP: begin
                if (tmr_done) begin
                    tmr_load = 1'b1;
`ifdef RRAM_VERIFY_EN
                    if (verify_pass_reg) begin
                        state_next = ST_VERIFY;
                        tmr_val    = READ_LD;
                    end else
`endif
                    begin
                        state_next = ST_PULSE;
                        tmr_val    = pw_load(op_reg);
                    end
                end
            end
            ST_PULSE: begin
                if (tmr_done) begin
                    state_next = ST_RECOVER;
                    tmr_load   = 1'b1;
                    tmr_val    = RECOVER_LD;
                end
            end
`ifdef RRAM_VERIFY_EN
            ST_VERIFY: begin
                if (tmr_done) begin
                    state_next = ST_RECOVER;
                    tmr_load   = 1'b1;
                    tmr_val    = RECOVER_LD;
                end
            end
`endif
            ST_RECOVER: begin
                if (tmr_done) begin
`ifdef RRAM_VERIFY_EN
                    // After a program pulse go read it back; after a failed
                    // read-back re-pulse while retries remain.
                    if ((!verify_pass_reg && op_reg != OP_READ) ||
                        (verify_pass_reg && verify_fail_reg &&
                         retry_reg < 3'(MAX_RETRY))) begin
                        state_next = ST_SETUP;
                        tmr_load   = 1'b1;
                        tmr_val    = SETUP_LD;
                    end else begin
                        state_next = ST_RESP;
                    end
`else
                    state_next = ST_RESP;
`endif
                end
            end
            ST_RESP: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State, request latches and registered outputs. Outputs are decoded
    // from state_next so they change on the same edge as the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= ST_IDLE;
            op_reg          <= OP_READ;
            row_reg         <= '0;
            mask_reg        <= '0;
            req_ready_reg   <= 1'b0;
            row_en_reg      <= 1'b0;
            bl_drive_reg    <= BL_OFF;
            sa_en_reg       <= 1'b0;
            rsp_valid_reg   <= 1'b0;
            rsp_data_reg    <= '0;
            rsp_err_reg     <= 1'b0;
`ifdef RRAM_VERIFY_EN
            verify_pass_reg <= 1'b0;
            verify_fail_reg <= 1'b0;
            retry_reg       <= '0;
`endif
        end else begin
            state_reg     <= state_next;
            req_ready_reg <= (state_next == ST_IDLE);
            rsp_valid_reg <= (state_next == ST_RESP);

            row_en_reg    <= (state_next == ST_SETUP) || (state_next == ST_PULSE)
`ifdef RRAM_VERIFY_EN
                             || (state_next == ST_VERIFY)
`endif
                             ;

            if (state_next == ST_PULSE)
                bl_drive_reg <= bl_for_op(op_reg);
`ifdef RRAM_VERIFY_EN
            else if (state_next == ST_VERIFY)
                bl_drive_reg <= BL_READ;
`endif
            else
                bl_drive_reg <= BL_OFF;

            sa_en_reg <= ((state_next == ST_PULSE) && (op_reg == OP_READ))
`ifdef RRAM_VERIFY_EN
                         || (state_next == ST_VERIFY)
`endif
                         ;

            if (accept) begin
                op_reg      <= op_e'(req_op);
                row_reg     <= req_row;
                mask_reg    <= req_mask;
                rsp_err_reg <= (op_e'(req_op) == OP_NOP);
                if (op_e'(req_op) == OP_NOP)
                    rsp_data_reg <= '0;
`ifdef RRAM_VERIFY_EN
                verify_pass_reg <= 1'b0;
                verify_fail_reg <= 1'b0;
                retry_reg       <= '0;
`endif
            end

            // Capture sense-amp data on the final read-bias cycle.
            if (state_reg == ST_PULSE && op_reg == OP_READ && tmr_done)
                rsp_data_reg <= rd_data;

`ifdef RRAM_VERIFY_EN
            if (state_reg == ST_VERIFY && tmr_done) begin
                rsp_data_reg    <= rd_data;
                verify_fail_reg <= !verify_ok(op_reg, rd_data, mask_reg);
            end

            if (state_reg == ST_RECOVER && tmr_done) begin
                if (!verify_pass_reg && op_reg != OP_READ) begin
                    verify_pass_reg <= 1'b1;
                end else if (verify_pass_reg && verify_fail_reg) begin
                    if (retry_reg < 3'(MAX_RETRY)) begin
                        retry_reg       <= retry_reg + 3'd1;
                        verify_pass_reg <= 1'b0;
                    end else begin
                        rsp_err_reg <= 1'b1;
                    end
                end
            end
`endif
        end
    end

    assign req_ready = req_ready_reg;
    assign row_en    = row_en_reg;
    assign row_addr  = row_reg;
    assign bl_drive  = bl_drive_reg;
    assign sa_en     = sa_en_reg;
    assign rsp_valid = rsp_valid_reg;
    assign rsp_data  = rsp_data_reg;
    assign rsp_err   = rsp_err_reg;

endmodule

// File: tb/tb_rram_row_sequencer.sv
// -----------------------------------------------------------------------------
// tb_rram_row_sequencer
// Directed requests with hand-computed responses pushed into a scoreboard
// queue at acceptance; an independent monitor pops and compares on rsp_valid
// and tracks word-line / bias activity between acceptance and response.
// Honours RRAM_VERIFY_EN when the design is built with it.
// -----------------------------------------------------------------------------
module tb_rram_row_sequencer;

`ifdef RRAM_VERIFY_EN
    localparam bit VER = 1'b1;
`else
    localparam bit VER = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        req_valid = 1'b0;
    logic [1:0]  req_op = 2'b00;
    logic [4:0]  req_row = 5'd0;
    logic [31:0] req_mask = 32'h0;
    logic [31:0] rd_data = 32'h0;
    logic        req_ready;
    logic        row_en;
    logic [4:0]  row_addr;
    logic [1:0]  bl_drive;
    logic        sa_en;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_err;

    rram_row_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_row   (req_row),
        .req_mask  (req_mask),
        .row_en    (row_en),
        .row_addr  (row_addr),
        .bl_drive  (bl_drive),
        .sa_en     (sa_en),
        .rd_data   (rd_data),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic [31:0] data;
        logic        err;
        int          lat;
        logic [4:0]  row;
        logic [1:0]  bl;
        int          n_row;
        int          n_sa;
        int          n_bl;
        int          n_pulse;
    } exp_t;

    exp_t q[$];
    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic exp_t mk(input int id, input logic [31:0] data, input logic err,
                                input int lat, input logic [4:0] row, input logic [1:0] bl,
                                input int n_row, input int n_sa, input int n_bl,
                                input int n_pulse);
        exp_t e;
        e.id = id; e.data = data; e.err = err; e.lat = lat; e.row = row; e.bl = bl;
        e.n_row = n_row; e.n_sa = n_sa; e.n_bl = n_bl; e.n_pulse = n_pulse;
        return e;
    endfunction

    // ---------------- monitor ----------------
    int cyc = 0;
    int acc_cyc = 0;
    int m_row = 0, m_sa = 0, m_bl = 0, m_pulse = 0;
    logic [1:0] bl_prev = 2'b00;

    always @(posedge clk) begin
        cyc++;
        if (rst_n && req_valid && req_ready) begin
            acc_cyc = cyc;
            m_row = 0; m_sa = 0; m_bl = 0; m_pulse = 0;
            bl_prev = 2'b00;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (row_en) m_row++;
        if (sa_en) m_sa++;
        if (q.size() > 0) begin
            if (bl_drive == q[0].bl) begin
                m_bl++;
                if (bl_prev != q[0].bl) m_pulse++;
            end
            if (row_en) chk("row_addr_stable", {27'b0, row_addr}, {27'b0, q[0].row});
        end
        bl_prev = bl_drive;
        if (bl_drive != 2'b00) chk("bl_only_with_row_en", {31'b0, row_en}, 32'd1);
        if (rsp_valid) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_rsp actual=rsp_valid required=no_response");
            end else begin
                e = q.pop_front();
                $display("txn %0d: lat=%0d data=%h err=%0d row_en_cyc=%0d sa_cyc=%0d bl_cyc=%0d pulses=%0d",
                         e.id, cyc - acc_cyc + 1, rsp_data, rsp_err, m_row, m_sa, m_bl, m_pulse);
                chk("latency",  cyc - acc_cyc + 1, e.lat);
                chk("rsp_data", rsp_data, e.data);
                chk("rsp_err",  {31'b0, rsp_err}, {31'b0, e.err});
                chk("row_en_cycles", m_row, e.n_row);
                chk("sa_en_cycles",  m_sa, e.n_sa);
                chk("bl_cycles",     m_bl, e.n_bl);
                chk("bl_pulses",     m_pulse, e.n_pulse);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic issue(input logic [1:0] op, input logic [4:0] row,
                         input logic [31:0] mask, input logic [31:0] rd, output bit ok);
        ok = 1'b0;
        @(negedge clk);
        req_op = op; req_row = row; req_mask = mask; rd_data = rd; req_valid = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(posedge clk);
            if (req_ready) ok = 1'b1;
        end
        if (!ok) begin
            total++; bad++;
            $display("FAIL accept_timeout actual=not_accepted required=accepted");
        end
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 300 && q.size() != 0; i++) @(negedge clk);
        if (q.size() != 0) begin
            total++; bad++;
            $display("FAIL rsp_timeout actual=pending=%0d required=0", q.size());
            q.delete();
        end
    endtask

    task automatic run_txn(input logic [1:0] op, input logic [4:0] row,
                           input logic [31:0] mask, input logic [31:0] rd, input exp_t e);
        bit ok;
        issue(op, row, mask, rd, ok);
        if (ok) q.push_back(e);
        @(negedge clk);
        req_valid = 1'b0;
        wait_drain();
    endtask

    initial begin
        int vx;
        bit ok;
        bit seen;
        vx = VER ? 8 : 0;   // extra latency of a passing read-back pass

        rst_n = 1'b0;
        #1;
        chk("rst_req_ready", {31'b0, req_ready}, 32'd0);
        chk("rst_row_en",    {31'b0, row_en}, 32'd0);
        chk("rst_bl_drive",  {30'b0, bl_drive}, 32'd0);
        chk("rst_sa_en",     {31'b0, sa_en}, 32'd0);
        chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("rst_rsp_data",  rsp_data, 32'd0);
        chk("rst_rsp_err",   {31'b0, rsp_err}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1 chk("ready_before_first_edge", {31'b0, req_ready}, 32'd0);
        @(negedge clk);
        chk("ready_after_release", {31'b0, req_ready}, 32'd1);

        // READ row 5
        run_txn(2'b00, 5'd5, 32'h0, 32'hA5A5_0F0F,
                mk(1, 32'hA5A5_0F0F, 1'b0, 9, 5'd5, 2'b11, 6, 4, 4, 1));
        // SET row 31
        run_txn(2'b01, 5'd31, 32'hFFFF_FFFF, VER ? 32'hFFFF_FFFF : 32'h1234_5678,
                mk(2, VER ? 32'hFFFF_FFFF : 32'hA5A5_0F0F, 1'b0, 13 + vx, 5'd31, 2'b01,
                   10 + (VER ? 6 : 0), VER ? 4 : 0, 8, 1));
        // RESET row 7, unmasked columns read 1 but masked ones are 0
        run_txn(2'b10, 5'd7, 32'h0000_00F0, 32'h0000_000F,
                mk(3, VER ? 32'h0000_000F : 32'hA5A5_0F0F, 1'b0, 17 + vx, 5'd7, 2'b10,
                   14 + (VER ? 6 : 0), VER ? 4 : 0, 12, 1));
        // reserved op
        run_txn(2'b11, 5'd9, 32'h0, 32'hDEAD_BEEF,
                mk(4, 32'h0, 1'b1, 1, 5'd9, 2'b11, 0, 0, 0, 0));
        // READ row 0
        run_txn(2'b00, 5'd0, 32'h0, 32'hFFFF_0000,
                mk(5, 32'hFFFF_0000, 1'b0, 9, 5'd0, 2'b11, 6, 4, 4, 1));

        // back-to-back with req_valid held high
        issue(2'b00, 5'd3, 32'h0, 32'h0BAD_F00D, ok);
        if (ok) begin
            q.push_back(mk(6, 32'h0BAD_F00D, 1'b0, 9, 5'd3, 2'b11, 6, 4, 4, 1));
            seen = 1'b0;
            for (int i = 0; i < 40 && !seen; i++) begin
                @(negedge clk);
                if (rsp_valid) seen = 1'b1;
                else chk("b2b_ready_low_while_busy", {31'b0, req_ready}, 32'd0);
            end
            chk("b2b_rsp_seen", {31'b0, seen}, 32'd1);
            chk("b2b_ready_in_rsp_cycle", {31'b0, req_ready}, 32'd0);
            @(negedge clk);
            chk("b2b_ready_after_rsp", {31'b0, req_ready}, 32'd1);
            q.push_back(mk(7, 32'h0BAD_F00D, 1'b0, 9, 5'd3, 2'b11, 6, 4, 4, 1));
            @(negedge clk);
            req_valid = 1'b0;
            wait_drain();
        end else begin
            req_valid = 1'b0;
        end

        // reset during cycle 4 of a RESET pulse
        issue(2'b10, 5'd12, 32'hFFFF_FFFF, 32'h0, ok);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (5) @(negedge clk);
        chk("midpulse_bl_reset", {30'b0, bl_drive}, 32'd2);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_row_en",    {31'b0, row_en}, 32'd0);
        chk("midrst_bl_drive",  {30'b0, bl_drive}, 32'd0);
        chk("midrst_req_ready", {31'b0, req_ready}, 32'd0);
        chk("midrst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_ready_after_release", {31'b0, req_ready}, 32'd1);
        repeat (20) @(negedge clk);

        // READ after reset recovery
        run_txn(2'b00, 5'd18, 32'h0, 32'h1357_9BDF,
                mk(8, 32'h1357_9BDF, 1'b0, 9, 5'd18, 2'b11, 6, 4, 4, 1));

`ifdef RRAM_VERIFY_EN
        // RESET with bit0 stuck at 1: four pulses then error
        run_txn(2'b10, 5'd2, 32'h0000_0001, 32'h0000_0001,
                mk(9, 32'h0000_0001, 1'b1, 97, 5'd2, 2'b10, 80, 16, 48, 4));
`endif

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/rram_row_sequencer.md
RRAM_ROW_SEQUENCER -- requirements
Module: rram_row_sequencer

Interface
REQ-001 SHALL have parameter SETUP_CYC, default 2, word-line settle cycles before the bias pulse (legal range 1..255).
REQ-002 SHALL have parameter SET_PW, default 8, SET pulse width in cycles (1..255).
REQ-003 SHALL have parameter RESET_PW, default 12, RESET pulse width in cycles (1..255).
REQ-004 SHALL have parameter READ_PW, default 4, read-bias width in cycles (1..255).
REQ-005 SHALL have parameter RECOVER_CYC, default 2, discharge cycles after each pulse (1..255).
REQ-006 SHALL have parameter MAX_RETRY, default 3, maximum extra program pulses under RRAM_VERIFY_EN (0..7).
REQ-007 SHALL have ports: clk in 1, single clock; rst_n in 1, asynchronous active-low reset.
REQ-008 SHALL have ports: req_valid in 1, request present; req_ready out 1, request accepted when both are high; req_op in 2, 00 READ, 01 SET, 10 RESET, 11 reserved; req_row in 5, target row; req_mask in 32, columns to program.
REQ-009 SHALL have ports: row_en out 1, drives the 5-to-32 word-line decoder enable; row_addr out 5, drives the decoder input.
REQ-010 SHALL have ports: bl_drive out 2, 00 off, 01 SET bias, 10 RESET bias, 11 read bias; sa_en out 1, sense-amp enable; rd_data in 32, sense-amp outputs.
REQ-011 SHALL have ports: rsp_valid out 1, single-cycle completion pulse; rsp_data out 32, read data; rsp_err out 1, verify failure.

Function
REQ-012 SHALL implement states IDLE, SETUP, PULSE, RECOVER, RESP (plus VERIFY under RRAM_VERIFY_EN).
REQ-013 SHALL assert req_ready only in IDLE; on acceptance it SHALL latch op, row and mask and enter SETUP on the next edge.
REQ-014 SHALL treat an op of 11 as a no-op: acceptance goes directly to RESP with rsp_data=0, rsp_err=1.
REQ-015 In SETUP, for SETUP_CYC cycles, it SHALL drive row_en=1, row_addr=the latched row, bl_drive=00.
REQ-016 In PULSE it SHALL drive row_en=1 and bl_drive per op, for SET_PW, RESET_PW or READ_PW cycles; sa_en=1 only during READ pulses.
REQ-017 SHALL sample rd_data into rsp_data on the last READ PULSE cycle; rsp_data SHALL be held until the next READ.
REQ-018 In RECOVER, for RECOVER_CYC cycles, it SHALL drive row_en=0 and bl_drive=00; it SHALL then go to RESP.
REQ-019 RESP SHALL last exactly one cycle with rsp_valid=1, then return to IDLE; there is no response backpressure.
REQ-020 Read latency from the accept edge to rsp_valid SHALL be SETUP_CYC+READ_PW+RECOVER_CYC+1 cycles (9 at defaults).
REQ-021 row_addr SHALL remain stable while row_en=1; bl_drive SHALL be nonzero only while row_en=1.
REQ-022 The duration counter SHALL be 8 bits, SHALL load (N-1) on state entry and SHALL advance on reaching 0.

Reset
REQ-023 rst_n low SHALL immediately force IDLE and all outputs to 0 except req_ready=0; req_ready SHALL rise the first cycle after release.
REQ-024 Reset mid-pulse SHALL drop row_en and bl_drive asynchronously, without entering RECOVER and without asserting rsp_valid.

Configuration
REQ-025 With RRAM_VERIFY_EN defined, a SET/RESET SHALL add RECOVER -> VERIFY (one READ pass: SETUP, READ_PW, RECOVER); a cell passes if SET reads 1 or RESET reads 0 on masked columns.
REQ-026 With RRAM_VERIFY_EN defined, on failure it SHALL re-pulse up to MAX_RETRY times; rsp_err SHALL be 1 if still failing, and rsp_data SHALL hold the last verify read.
REQ-027 Without RRAM_VERIFY_EN, rsp_err SHALL be 0 except for the op 11 case, and there SHALL be no VERIFY state or retry logic.

Structure
REQ-028 A shared package rram_pkg SHALL hold the op encodings, bl_drive encodings, the state enum and the 8-bit counter width.
REQ-029 The sub-module rram_pulse_timer (a loadable down-counter with a done flag) SHALL be the only instance.

Verification
REQ-030 READ row 5, rd_data=0xA5A5_0F0F -> row_addr=5, row_en high cycles 1..6, sa_en cycles 3..6, rsp_valid at cycle 9 with rsp_data=0xA5A5_0F0F.
REQ-031 SET row 31 -> bl_drive=01 for exactly 8 cycles, row_en low within RECOVER, rsp_valid at cycle 13, rsp_err=0.
REQ-032 Back-to-back req_valid held high -> the second request is accepted only the cycle after the rsp_valid pulse.
REQ-033 rst_n low during cycle 4 of a RESET pulse -> row_en=0 and bl_drive=00 immediately, no rsp_valid, req_ready=1 after release.
REQ-034 RRAM_VERIFY_EN, RESET with mask=0x1 and rd_data bit0 stuck at 1 -> 4 RESET pulses total, then rsp_err=1.
REQ-035 op=11 -> rsp_valid one cycle after acceptance, rsp_err=1, row_en never asserted.
